// File: rtl/lp_checker.sv
`default_nettype none
// ============================================================================
// Module   : lp_checker
// Desc     : Forward-edge CFI landing-pad enforcer stage between fetch and decode.
//            Optional LPAD label compare enabled by defining LP_LABEL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lp_checker #(
  parameter int unsigned VLEN  = 64,  // matches riscv::VLEN on RV64 builds
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             lp_en_i,
  input  logic [31:0]      expected_label_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [VLEN-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic [VLEN-1:0]  out_pc_o,
  output logic             out_lp_fault_o,
  output logic             lp_expected_o,
  output logic [CNT_W-1:0] viol_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPECT = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic [VLEN-1:0]  r_out_pc;
  logic             r_out_fault;
  logic [CNT_W-1:0] r_viol_cnt;

  logic w_accept;
  logic w_jalr_lp;
  logic w_cjr_lp;
  logic w_needs_lp;
  logic w_is_lpad;
  logic w_label_ok;
  logic w_lpad_ok;
  logic w_fault;
  logic w_latch;

  // Link registers (x1/x5/x7) mark returns and software-guarded calls.
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5) || (r == 5'd7);
  endfunction

  assign in_ready_o = (~r_out_valid | out_ready_i) & (r_state != ST_FAULT);
  assign w_accept   = in_valid_i & in_ready_o;

  assign w_jalr_lp  = (in_instr_i[6:0] == 7'b1100111) & ~is_link_reg(in_instr_i[19:15]);
  assign w_cjr_lp   = (in_instr_i[1:0] == 2'b10) & (in_instr_i[15:13] == 3'b100) &
                      (in_instr_i[6:2] == 5'd0) & (in_instr_i[11:7] != 5'd0) &
                      ~is_link_reg(in_instr_i[11:7]);
  assign w_needs_lp = w_jalr_lp | w_cjr_lp;

  assign w_is_lpad  = (in_instr_i[6:0] == 7'b0010111) & (in_instr_i[11:7] == 5'd0) &
                      (in_pc_i[1:0] == 2'b00);
  assign w_lpad_ok  = w_is_lpad & w_label_ok;

`ifdef LP_LABEL_CHECK_EN
  logic [19:0] r_label;
  logic        w_unused_label_lo;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_label <= 20'd0;
    end else if (w_latch) begin
      r_label <= expected_label_i[31:12];
    end
  end

  // A zero label is the wildcard pad and always passes.
  assign w_label_ok        = (in_instr_i[31:12] == 20'd0) | (in_instr_i[31:12] == r_label);
  assign w_unused_label_lo = ^expected_label_i[11:0];
`else
  logic w_unused_label;

  assign w_label_ok     = 1'b1;
  assign w_unused_label = ^{expected_label_i, w_latch};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fault     = 1'b0;
    w_latch     = 1'b0;
    if (!lp_en_i) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_needs_lp) begin
            w_state_nxt = ST_EXPECT;
            w_latch     = 1'b1;
          end
        end
        ST_EXPECT: begin
          if (w_lpad_ok) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FAULT;
            w_fault     = 1'b1;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_pc    <= '0;
      r_out_fault <= 1'b0;
      r_viol_cnt  <= '0;
    end else if (flush_i) begin
      // Flush wins over any same-cycle accept; the counter is history and survives.
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= in_instr_i;
        r_out_pc    <= in_pc_i;
        r_out_fault <= w_fault;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_fault && (r_viol_cnt != {CNT_W{1'b1}})) begin
        r_viol_cnt <= r_viol_cnt + c_CNT_ONE;
      end
    end
  end

  assign out_valid_o    = r_out_valid;
  assign out_instr_o    = r_out_instr;
  assign out_pc_o       = r_out_pc;
  assign out_lp_fault_o = r_out_fault;
  assign lp_expected_o  = (r_state == ST_EXPECT);
  assign viol_cnt_o     = r_viol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lp_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lp_checker
// Desc     : Directed and randomized checks of lp_checker against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lp_checker;

  localparam int VLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [31:0] JALR_X10 = 32'h0005_0067;
  localparam logic [31:0] JALR_X1  = 32'h0000_8067;
  localparam logic [31:0] CJR_X10  = 32'h0000_8502;
  localparam logic [31:0] LPAD0    = 32'h0000_0017;
  localparam logic [31:0] ADDI     = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             lp_en;
  logic [31:0]      exp_label;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [VLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [VLEN-1:0]  out_pc;
  logic             out_fault;
  logic             lp_expected;
  logic [CNT_W-1:0] viol_cnt;

  lp_checker #(.VLEN(VLEN), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .lp_en_i          (lp_en),
    .expected_label_i (exp_label),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_instr_i       (in_instr),
    .in_pc_i          (in_pc),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc),
    .out_lp_fault_o   (out_fault),
    .lp_expected_o    (lp_expected),
    .viol_cnt_o       (viol_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: "a pad is owed", "stream is frozen awaiting flush", plus the output slot.
  bit              m_owed;
  bit              m_frozen;
  bit              m_ovalid;
  bit              m_ofault;
  logic [31:0]     m_oinstr;
  logic [VLEN-1:0] m_opc;
  logic [19:0]     m_label;
  int              m_cnt;

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5) || (r == 5'd7);
  endfunction

  function automatic bit wants_pad(input logic [31:0] i);
    if (i[6:0] == 7'h67) return !is_link(i[19:15]);
    if (i[1:0] == 2'b10 && i[15:13] == 3'b100 && i[6:2] == 5'd0 && i[11:7] != 5'd0)
      return !is_link(i[11:7]);
    return 1'b0;
  endfunction

  function automatic bit pad_ok(input logic [31:0] i, input logic [VLEN-1:0] pc);
    bit ok;
    ok = (i[6:0] == 7'h17) && (i[11:7] == 5'd0) && (pc[1:0] == 2'b00);
`ifdef LP_LABEL_CHECK_EN
    if (i[31:12] != 20'd0 && i[31:12] != m_label) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic model_reset();
    m_owed = 0; m_frozen = 0; m_ovalid = 0; m_ofault = 0;
    m_oinstr = '0; m_opc = '0; m_label = '0; m_cnt = 0;
  endtask

  task automatic model_step(input bit rdy);
    bit acc;
    bit f;
    acc = in_valid && rdy;
    if (flush) begin
      m_ovalid = 0; m_owed = 0; m_frozen = 0; m_ofault = 0;
    end else begin
      if (acc) begin
        f = lp_en && m_owed && !pad_ok(in_instr, in_pc);
        m_ovalid = 1; m_oinstr = in_instr; m_opc = in_pc; m_ofault = f;
        if (f) begin
          m_frozen = 1; m_owed = 0;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else if (lp_en && m_owed) begin
          m_owed = 0;
        end else if (lp_en && wants_pad(in_instr)) begin
          m_owed = 1; m_label = exp_label[31:12];
        end
      end else if (out_ready) begin
        m_ovalid = 0;
      end
      if (!lp_en) begin
        m_owed = 0; m_frozen = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("out_valid", out_valid, m_ovalid);
    chk("lp_expected", lp_expected, m_owed);
    chk("viol_cnt", viol_cnt, m_cnt);
    if (m_ovalid) begin
      chk("out_instr", out_instr, m_oinstr);
      chk("out_pc", out_pc, m_opc);
      chk("out_fault", out_fault, m_ofault);
    end
  endtask

  // Called at a negedge with inputs already set for the coming posedge.
  task automatic cycle();
    bit rdy;
    #1;
    rdy = (!m_ovalid || out_ready) && !m_frozen;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    model_step(rdy);
    @(negedge clk);
    chk_outputs();
  endtask

  task automatic send(input logic [31:0] i, input logic [VLEN-1:0] pc);
    in_valid = 1'b1; in_instr = i; in_pc = pc;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  l;
    r = $urandom;
    l = ($urandom_range(0, 2) == 0) ? 5'd1 : (($urandom_range(0, 1) == 0) ? 5'd5 : 5'd7);
    case ($urandom_range(0, 5))
      0:       return {r[31:20], r[19:15], 3'b000, 5'd0, 7'h67};
      1:       return {r[31:20], l, 3'b000, r[11:7], 7'h67};
      2:       return {16'h0, 3'b100, r[12], r[11:7], 5'd0, 2'b10};
      3:       return {17'h0, r[14:12], 5'd0, 7'h17};
      4:       return {r[31:7], 7'h13};
      default: return r;
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; lp_en = 1'b0; exp_label = '0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_lp_expected", lp_expected, 0);
    chk("rst_viol_cnt", viol_cnt, 0);
    rst = 1'b0; lp_en = 1'b1;
    @(negedge clk);

    // Indirect jump followed by an aligned pad.
    send(JALR_X10, 64'hffc);
    chk("s1_expect_set", lp_expected, 1);
    send(LPAD0, 64'h1000);
    chk("s1_no_fault", out_fault, 0);
    chk("s1_expect_clr", lp_expected, 0);

    // Missing pad freezes the stage until flush.
    send(JALR_X10, 64'h2000);
    send(ADDI, 64'h2004);
    chk("s2_fault", out_fault, 1);
    chk("s2_cnt", viol_cnt, 1);
    in_valid = 1'b1; in_instr = ADDI; in_pc = 64'h2008;
    repeat (2) cycle();
    chk("s2_stall", in_ready, 0);
    do_flush();
    in_valid = 1'b0;
    chk("s2_flush_valid", out_valid, 0);
    chk("s2_ready_back", in_ready, 1);

    // Return through x1 does not require a pad.
    send(JALR_X1, 64'h3000);
    chk("s3_idle", lp_expected, 0);
    send(ADDI, 64'h3004);
    chk("s3_no_fault", out_fault, 0);

    // Compressed jump then misaligned pad.
    send(CJR_X10, 64'h4000);
    chk("s4_expect", lp_expected, 1);
    send(LPAD0, 64'h1002);
    chk("s4_misaligned", out_fault, 1);
    do_flush();

`ifdef LP_LABEL_CHECK_EN
    exp_label = 32'h0000_5000;
    send(JALR_X10, 64'h5000);
    send(32'h0000_5017, 64'h5100);
    chk("lbl_pass", out_fault, 0);
    send(JALR_X10, 64'h5200);
    send(32'h0000_6017, 64'h5300);
    chk("lbl_fault", out_fault, 1);
    do_flush();
    exp_label = '0;
`endif

    // Backpressure with a jump in flight, then flush drops it.
    cycle();
    out_ready = 1'b0;
    send(JALR_X10, 64'h6000);
    chk("s6_loaded", out_valid, 1);
    repeat (3) cycle();
    chk("s6_held", out_instr, JALR_X10);
    do_flush();
    out_ready = 1'b1;
    chk("s6_dropped", out_valid, 0);
    chk("s6_idle", lp_expected, 0);

    // Enforcement disabled: no pad owed, no fault.
    lp_en = 1'b0;
    send(JALR_X10, 64'h7000);
    chk("dis_idle", lp_expected, 0);
    send(ADDI, 64'h7004);
    chk("dis_no_fault", out_fault, 0);
    lp_en = 1'b1;
    send(JALR_X10, 64'h7100);
    lp_en = 1'b0;
    cycle();
    chk("dis_forced_idle", lp_expected, 0);
    lp_en = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = {32'h0, $urandom_range(0, 32'h0fff_fff0) & 32'hffff_fffc};
      if ($urandom_range(0, 3) == 0) in_pc[1:0] = 2'b10;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0) || (m_frozen && $urandom_range(0, 3) == 0);
      exp_label = {12'h0, 5'h0, 3'($urandom_range(0, 7)), 12'($urandom)};
      if ($urandom_range(0, 63) == 0) lp_en = ~lp_en;
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; lp_en = 1'b1;
    do_flush();

    for (int n = 0; n < CNT_MAX + 5; n++) begin
      send(JALR_X10, 64'h8000);
      send(ADDI, 64'h8004);
      do_flush();
    end
    chk("cnt_saturated", viol_cnt, CNT_MAX);

    // Asynchronous reset mid-operation.
    send(JALR_X10, 64'h9000);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_lp_expected", lp_expected, 0);
    chk("arst_viol_cnt", viol_cnt, 0);
    chk("arst_out_pc", out_pc, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
